// File: rtl/psram_port_arbiter_if.sv
// Request/response bundle between the CPU iomem window, the SPI command logger
// and the PSRAM controller port. The arbiter connects as slave, its environment as master.
interface psram_port_arbiter_if #(
  parameter int ADDR_W    = 24,
  parameter int LOG_DEPTH = 8
);
  localparam int CNT_W = $clog2(LOG_DEPTH) + 1;

  logic              cpu_valid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [3:0]        cpu_wstrb;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;

  logic              log_valid;
  logic [ADDR_W-1:0] log_addr;
  logic [31:0]       log_wdata;
  logic              log_ready;
  logic [CNT_W-1:0]  log_level;

  logic              ram_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_wstrb;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_ready;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  log_valid, log_addr, log_wdata,
    output log_ready, log_level,
    output ram_valid, ram_addr, ram_wstrb, ram_wdata,
    input  ram_rdata, ram_ready
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output log_valid, log_addr, log_wdata,
    input  log_ready, log_level,
    input  ram_valid, ram_addr, ram_wstrb, ram_wdata,
    output ram_rdata, ram_ready
  );
endinterface

// File: rtl/psram_port_arbiter.sv
// Shares one PSRAM controller port between blocking CPU accesses and posted logger
// writes; logger writes are buffered in a circular FIFO and arbitrated round-robin.
module psram_port_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int LOG_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  psram_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam int CNT_W = $clog2(LOG_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(LOG_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_BUSY = 2'd1,
    LOG_BUSY = 2'd2,
    CPU_ACK  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              last_grant_cpu_r;
  logic              grant_cpu_s;
  logic              grant_log_s;
  logic              cpu_done_s;
  logic              log_done_s;
  logic              log_pend_s;
  logic              log_ready_s;
  logic              push_s;

  logic [ADDR_W-1:0] fifo_addr_r [LOG_DEPTH];
  logic [31:0]       fifo_data_r [LOG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  level_r;

  logic              ram_valid_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [3:0]        ram_wstrb_r;
  logic [31:0]       ram_wdata_r;
  logic [31:0]       cpu_rdata_r;
  logic              cpu_ready_r;

  assign log_ready_s   = (level_r != FULL_LVL);
  assign log_pend_s    = (level_r != {CNT_W{1'b0}});
  assign push_s        = bus.log_valid && log_ready_s;

  assign bus.log_ready = log_ready_s;
  assign bus.log_level = level_r;
  assign bus.ram_valid = ram_valid_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wstrb = ram_wstrb_r;
  assign bus.ram_wdata = ram_wdata_r;
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.cpu_ready = cpu_ready_r;

  // Grant decision and next state; a full FIFO wins over round-robin fairness
  always_comb begin
    state_nxt_s = state_r;
    grant_cpu_s = 1'b0;
    grant_log_s = 1'b0;
    cpu_done_s  = 1'b0;
    log_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (level_r == FULL_LVL) begin
          grant_log_s = 1'b1;
          state_nxt_s = LOG_BUSY;
        end else if (bus.cpu_valid && log_pend_s) begin
          if (last_grant_cpu_r) begin
            grant_log_s = 1'b1;
            state_nxt_s = LOG_BUSY;
          end else begin
            grant_cpu_s = 1'b1;
            state_nxt_s = CPU_BUSY;
          end
        end else if (bus.cpu_valid) begin
          grant_cpu_s = 1'b1;
          state_nxt_s = CPU_BUSY;
        end else if (log_pend_s) begin
          grant_log_s = 1'b1;
          state_nxt_s = LOG_BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CPU_BUSY: begin
        if (bus.ram_ready) begin
          cpu_done_s  = 1'b1;
          state_nxt_s = CPU_ACK;
        end else begin
          state_nxt_s = CPU_BUSY;
        end
      end
      LOG_BUSY: begin
        if (bus.ram_ready) begin
          log_done_s  = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LOG_BUSY;
        end
      end
      CPU_ACK: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register and round-robin history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      last_grant_cpu_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_cpu_s || grant_log_s) begin
        last_grant_cpu_r <= grant_cpu_s;
      end
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= bus.log_addr;
      fifo_data_r[wr_ptr_r] <= bus.log_wdata;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle cancel out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (log_done_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (push_s && !log_done_s) begin
        level_r <= level_r + CNT_W'(1);
      end else if (!push_s && log_done_s) begin
        level_r <= level_r - CNT_W'(1);
      end
    end
  end

  // Downstream request and CPU response registers; ram_* frozen while ram_valid is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_valid_r <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wstrb_r <= 4'h0;
      ram_wdata_r <= 32'h0000_0000;
      cpu_rdata_r <= 32'h0000_0000;
      cpu_ready_r <= 1'b0;
    end else begin
      cpu_ready_r <= cpu_done_s;
      if (grant_cpu_s) begin
        ram_valid_r <= 1'b1;
        ram_addr_r  <= bus.cpu_addr;
        ram_wstrb_r <= bus.cpu_wstrb;
        ram_wdata_r <= bus.cpu_wdata;
      end else if (grant_log_s) begin
        ram_valid_r <= 1'b1;
        ram_addr_r  <= fifo_addr_r[rd_ptr_r];
        ram_wstrb_r <= 4'hF;
        ram_wdata_r <= fifo_data_r[rd_ptr_r];
      end else if (cpu_done_s || log_done_s) begin
        ram_valid_r <= 1'b0;
      end
      if (cpu_done_s) begin
        cpu_rdata_r <= (ram_wstrb_r == 4'h0) ? bus.ram_rdata : 32'h0000_0000;
      end
    end
  end
endmodule

// File: tb/tb_psram_port_arbiter.sv
// Directed bench for psram_port_arbiter: a vector table of single accesses plus
// hand-written sequences for round-robin, full-FIFO override, pointer wrap and reset.
module tb_psram_port_arbiter;
  localparam int ADDR_W    = 24;
  localparam int LOG_DEPTH = 8;

  typedef struct {
    bit                is_cpu;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wstrb;
    logic [31:0]       wdata;
    logic [31:0]       ram_rd;
    int                lat;
    logic [31:0]       exp_rdata;
    logic [3:0]        exp_strb;
  } vec_t;

  logic clk;
  logic reset;
  int   tests;
  int   failed;
  int   ram_lat;
  logic [31:0] ram_rd_cfg;

  logic [ADDR_W-1:0] rec_addr [$];
  logic [3:0]        rec_wstrb [$];
  logic [31:0]       rec_wdata [$];

  psram_port_arbiter_if #(.ADDR_W(ADDR_W), .LOG_DEPTH(LOG_DEPTH)) bus ();

  psram_port_arbiter #(.ADDR_W(ADDR_W), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Downstream model: ram_ready pulses ram_lat cycles after ram_valid rises; every access is logged
  initial begin : ram_model
    int cnt;
    logic [ADDR_W-1:0] a0;
    logic [3:0]        s0;
    logic [31:0]       d0;
    cnt = 0;
    bus.ram_ready = 1'b0;
    bus.ram_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.ram_ready) begin
        bus.ram_ready = 1'b0;
        cnt = 0;
      end else if (bus.ram_valid === 1'b1) begin
        if (cnt == 0) begin
          a0 = bus.ram_addr;
          s0 = bus.ram_wstrb;
          d0 = bus.ram_wdata;
          rec_addr.push_back(a0);
          rec_wstrb.push_back(s0);
          rec_wdata.push_back(d0);
        end
        cnt++;
        if (cnt >= ram_lat) begin
          check("ram_stable_addr", bus.ram_addr, a0);
          check("ram_stable_wstrb", bus.ram_wstrb, s0);
          check("ram_stable_wdata", bus.ram_wdata, d0);
          bus.ram_rdata = ram_rd_cfg;
          bus.ram_ready = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic wait_cpu_ready(input string name, output int cyc);
    cyc = 0;
    while (bus.cpu_ready !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.cpu_ready !== 1'b1) begin
      tests++;
      failed++;
      $display("FAIL %s_timeout: cpu_ready 0 required 1 within 1000 cycles", name);
    end
  endtask

  // Blocking CPU access; returns cycles to ram_valid and to cpu_ready, counted in negedges
  task automatic cpu_access(input string name, input logic [ADDR_W-1:0] a, input logic [3:0] s,
                            input logic [31:0] d, output logic [31:0] rd,
                            output int rv_lat, output int rdy_lat);
    int w;
    @(negedge clk);
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wstrb = s;
    bus.cpu_wdata = d;
    rv_lat = 0;
    while (bus.ram_valid !== 1'b1 && rv_lat < 1000) begin
      @(negedge clk);
      rv_lat++;
    end
    wait_cpu_ready(name, w);
    rdy_lat = rv_lat + w;
    rd = bus.cpu_rdata;
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    check({name, "_ready_pulse"}, {31'h0, bus.cpu_ready}, 32'h0);
  endtask

  task automatic log_push(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    int n;
    n = 0;
    bus.log_valid = 1'b1;
    bus.log_addr  = a;
    bus.log_wdata = d;
    while (bus.log_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (bus.log_ready !== 1'b1) begin
      tests++;
      failed++;
      $display("FAIL log_push_timeout: log_ready 0 required 1 within 1000 cycles");
    end
    @(negedge clk);
    bus.log_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((bus.log_level != 0 || bus.ram_valid !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (bus.log_level != 0 || bus.ram_valid !== 1'b0) begin
      tests++;
      failed++;
      $display("FAIL %s_drain_timeout: level %0d required 0", name, bus.log_level);
    end
    @(negedge clk);
  endtask

  task automatic expect_ram(input string name, input logic [ADDR_W-1:0] a, input logic [3:0] s,
                            input logic [31:0] d);
    if (rec_addr.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s: no downstream access recorded, required addr 0x%06h", name, a);
    end else begin
      check({name, "_addr"}, rec_addr.pop_front(), a);
      check({name, "_wstrb"}, rec_wstrb.pop_front(), s);
      check({name, "_wdata"}, rec_wdata.pop_front(), d);
    end
  endtask

  initial begin : main
    vec_t vecs [6];
    logic [31:0] rd;
    int rv;
    int rl;
    int w;
    int pushed;
    int pp4;
    int guard;
    bit chk_pending;
    logic [31:0] lvl_exp;

    tests = 0;
    failed = 0;
    ram_lat = 1;
    ram_rd_cfg = 32'h0;
    reset = 1'b1;
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wstrb = 4'h0;
    bus.cpu_wdata = 32'h0;
    bus.log_valid = 1'b0;
    bus.log_addr  = '0;
    bus.log_wdata = 32'h0;

    vecs[0] = '{1'b1, 24'h000100, 4'h0, 32'h0,         32'hDEADBEEF, 5, 32'hDEADBEEF, 4'h0};
    vecs[1] = '{1'b1, 24'h000204, 4'h3, 32'hCAFE1234,  32'h55AA55AA, 2, 32'h00000000, 4'h3};
    vecs[2] = '{1'b1, 24'hFFFFFC, 4'h0, 32'h0,         32'h0BADF00D, 1, 32'h0BADF00D, 4'h0};
    vecs[3] = '{1'b0, 24'h000010, 4'hF, 32'h11111111,  32'h0,        4, 32'h0,        4'hF};
    vecs[4] = '{1'b0, 24'h000014, 4'hF, 32'h22222222,  32'h0,        4, 32'h0,        4'hF};
    vecs[5] = '{1'b0, 24'h000018, 4'hF, 32'h33333333,  32'h0,        4, 32'h0,        4'hF};

    repeat (3) @(negedge clk);
    check("rst_ram_valid", {31'h0, bus.ram_valid}, 32'h0);
    check("rst_cpu_ready", {31'h0, bus.cpu_ready}, 32'h0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("rst_log_level", {28'h0, bus.log_level}, 32'h0);
    check("rst_log_ready", {31'h0, bus.log_ready}, 32'h1);
    check("rst_ram_addr", {8'h0, bus.ram_addr}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Vector table: CPU accesses one at a time, logger writes pushed back-to-back
    for (int i = 0; i < 6; i++) begin
      ram_lat = vecs[i].lat;
      ram_rd_cfg = vecs[i].ram_rd;
      if (vecs[i].is_cpu) begin
        cpu_access($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, rd, rv, rl);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        check($sformatf("vec%0d_ram_valid_lat", i), rv, 32'd1);
        check($sformatf("vec%0d_cpu_ready_lat", i), rl, vecs[i].lat + 1);
        expect_ram($sformatf("vec%0d_ram", i), vecs[i].addr, vecs[i].exp_strb, vecs[i].wdata);
      end else begin
        log_push(vecs[i].addr, vecs[i].wdata);
      end
    end
    check("log_level_after_3_pushes", {28'h0, bus.log_level}, 32'd3);
    wait_drain("log3");
    check("log_level_drained", {28'h0, bus.log_level}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].is_cpu) begin
        expect_ram($sformatf("vec%0d_ram", i), vecs[i].addr, vecs[i].exp_strb, vecs[i].wdata);
      end
    end

    // Round-robin: CPU and logger contend with last grant = LOG
    ram_lat = 3;
    ram_rd_cfg = 32'h12345678;
    fork
      begin
        logic [31:0] r1;
        int a1;
        int b1;
        cpu_access("alt_cpu1", 24'h000400, 4'h0, 32'h0, r1, a1, b1);
        check("alt_cpu1_rdata", r1, 32'h12345678);
        cpu_access("alt_cpu2", 24'h000408, 4'h0, 32'h0, r1, a1, b1);
        check("alt_cpu2_rdata", r1, 32'h12345678);
      end
      begin
        log_push(24'h000300, 32'hAAAA0001);
        log_push(24'h000304, 32'hAAAA0002);
      end
    join
    wait_drain("alt");
    expect_ram("alt_0_cpu", 24'h000400, 4'h0, 32'h0);
    expect_ram("alt_1_log", 24'h000300, 4'hF, 32'hAAAA0001);
    expect_ram("alt_2_cpu", 24'h000408, 4'h0, 32'h0);
    expect_ram("alt_3_log", 24'h000304, 4'hF, 32'hAAAA0002);

    // Full FIFO: filled during a long CPU access, then LOG wins although cpu_valid stays high
    ram_lat = 20;
    ram_rd_cfg = 32'h600DF00D;
    @(negedge clk);
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 24'h000500;
    bus.cpu_wstrb = 4'h0;
    bus.cpu_wdata = 32'h0;
    guard = 0;
    while (bus.ram_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 8; i++) begin
      log_push(24'h000800 + 24'(4 * i), 32'hF0000000 + 32'(i));
    end
    check("full_level", {28'h0, bus.log_level}, 32'd8);
    check("full_log_ready", {31'h0, bus.log_ready}, 32'h0);
    ram_lat = 2;
    wait_cpu_ready("full_cpu1", w);
    check("full_cpu1_rdata", bus.cpu_rdata, 32'h600DF00D);
    bus.cpu_addr = 24'h000504;
    @(negedge clk);
    check("full_cpu1_ready_pulse", {31'h0, bus.cpu_ready}, 32'h0);
    wait_cpu_ready("full_cpu2", w);
    check("full_cpu2_rdata", bus.cpu_rdata, 32'h600DF00D);
    bus.cpu_valid = 1'b0;
    wait_drain("full");
    expect_ram("full_cpu1", 24'h000500, 4'h0, 32'h0);
    expect_ram("full_log0", 24'h000800, 4'hF, 32'hF0000000);
    expect_ram("full_cpu2", 24'h000504, 4'h0, 32'h0);
    for (int i = 1; i < 8; i++) begin
      expect_ram($sformatf("full_log%0d", i), 24'h000800 + 24'(4 * i), 4'hF, 32'hF0000000 + 32'(i));
    end

    // Pointer wrap: hold the level at 4 by pushing only when a pop is due
    ram_lat = 3;
    pushed = 0;
    pp4 = 0;
    guard = 0;
    chk_pending = 1'b0;
    lvl_exp = 32'h0;
    while (pushed < 20 && guard < 2000) begin
      @(negedge clk);
      #1;
      guard++;
      if (chk_pending) begin
        check("pushpop_level", {28'h0, bus.log_level}, lvl_exp);
        chk_pending = 1'b0;
      end
      if ((bus.log_level < 4 || bus.ram_ready === 1'b1) && bus.log_ready === 1'b1) begin
        bus.log_valid = 1'b1;
        bus.log_addr  = 24'h000900 + 24'(4 * pushed);
        bus.log_wdata = 32'h5A000000 + 32'(pushed);
        if (bus.ram_ready === 1'b1) begin
          chk_pending = 1'b1;
          lvl_exp = {28'h0, bus.log_level};
          if (bus.log_level == 4) begin
            pp4++;
          end
        end
        pushed++;
      end else begin
        bus.log_valid = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    if (chk_pending) begin
      check("pushpop_level", {28'h0, bus.log_level}, lvl_exp);
    end
    bus.log_valid = 1'b0;
    check("wrap_pushed", pushed, 32'd20);
    check("pushpop_at_level4_seen", {31'h0, pp4 > 0}, 32'h1);
    wait_drain("wrap");
    for (int i = 0; i < 20; i++) begin
      expect_ram($sformatf("wrap%0d", i), 24'h000900 + 24'(4 * i), 4'hF, 32'h5A000000 + 32'(i));
    end

    // Reset during LOG_BUSY drops the request and empties the FIFO at once
    ram_lat = 10;
    @(negedge clk);
    log_push(24'h000A00, 32'h77777777);
    guard = 0;
    while (bus.ram_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    log_push(24'h000A04, 32'h77777778);
    log_push(24'h000A08, 32'h77777779);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_ram_valid", {31'h0, bus.ram_valid}, 32'h0);
    check("rst_mid_log_level", {28'h0, bus.log_level}, 32'h0);
    check("rst_mid_log_ready", {31'h0, bus.log_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    rec_addr.delete();
    rec_wstrb.delete();
    rec_wdata.delete();
    ram_lat = 2;
    ram_rd_cfg = 32'h13572468;
    cpu_access("post_rst", 24'h000A10, 4'h0, 32'h0, rd, rv, rl);
    check("post_rst_rdata", rd, 32'h13572468);
    expect_ram("post_rst_ram", 24'h000A10, 4'h0, 32'h0);
    repeat (10) @(negedge clk);
    check("post_rst_no_stale_log", rec_addr.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
